// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - SPI command-word decoder driving a byte-wide single-port RAM
// Accepts address/data command words and streams read bytes back for MISO.
module spi_ram_ctrl #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [9:0] i_rx_data,
   input  logic       i_rx_valid,
   output logic [7:0] o_tx_data,
   output logic       o_tx_valid,
   output logic       o_cmd_err
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_FETCH = 2'd1,
      RD_SEND  = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [7:0]           r_mem [MEM_DEPTH];
   logic [ADDR_SIZE-1:0] r_wr_addr;
   logic [ADDR_SIZE-1:0] r_rd_addr;
   logic                 r_wr_addr_ok;
   logic                 r_rd_addr_ok;
   logic                 w_wr_addr_ld;
   logic                 w_mem_we;
   logic                 w_rd_addr_ld;
   logic                 w_err;

   always_comb begin
      w_next_state = r_state;
      w_wr_addr_ld = 1'b0;
      w_mem_we     = 1'b0;
      w_rd_addr_ld = 1'b0;
      w_err        = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_rx_valid) begin
               case (i_rx_data[9:8])
                  2'b00: w_wr_addr_ld = 1'b1;
                  2'b01: begin
                     if (r_wr_addr_ok) w_mem_we = 1'b1;
                     else              w_err    = 1'b1;
                  end
                  2'b10: w_rd_addr_ld = 1'b1;
                  default: begin
                     if (r_rd_addr_ok) w_next_state = RD_FETCH;
                     else              w_err        = 1'b1;
                  end
               endcase
            end
         end
         // The single RAM port is owned by the read in progress, so any word is lost.
         RD_FETCH: begin
            w_next_state = RD_SEND;
            w_err        = i_rx_valid;
         end
         RD_SEND: begin
            w_next_state = IDLE;
            w_err        = i_rx_valid;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_addr    <= '0;
         r_rd_addr    <= '0;
         r_wr_addr_ok <= 1'b0;
         r_rd_addr_ok <= 1'b0;
         o_tx_data    <= 8'h00;
         o_tx_valid   <= 1'b0;
         o_cmd_err    <= 1'b0;
      end else begin
         o_cmd_err  <= w_err;
         o_tx_valid <= (r_state == RD_FETCH);
         if (w_wr_addr_ld) begin
            r_wr_addr    <= i_rx_data[ADDR_SIZE-1:0];
            r_wr_addr_ok <= 1'b1;
         end else if (w_mem_we) begin
            r_wr_addr <= r_wr_addr + ADDR_SIZE'(1);
         end
         if (w_rd_addr_ld) begin
            r_rd_addr    <= i_rx_data[ADDR_SIZE-1:0];
            r_rd_addr_ok <= 1'b1;
         end else if (r_state == RD_SEND) begin
            r_rd_addr <= r_rd_addr + ADDR_SIZE'(1);
         end
         if (r_state == RD_FETCH) o_tx_data <= r_mem[r_rd_addr];
      end
   end

   // RAM contents survive reset, so the array sits outside the reset domain.
   always_ff @(posedge i_clk) begin
      if (w_mem_we) r_mem[r_wr_addr] <= i_rx_data[7:0];
   end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb/tb_spi_ram_ctrl.sv - vector table, corner sequences and randomized model check for spi_ram_ctrl
module tb_spi_ram_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] rx_data = 10'h000;
   logic       rx_valid = 1'b0;
   wire  [7:0] tx_data;
   wire        tx_valid;
   wire        cmd_err;

   int checks = 0;
   int errors = 0;

   spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_rx_data  (rx_data),
      .i_rx_valid (rx_valid),
      .o_tx_data  (tx_data),
      .o_tx_valid (tx_valid),
      .o_cmd_err  (cmd_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [9:0] d;
      logic       tv;
      logic [7:0] td;
      logic       err;
   } vec_t;

   vec_t tab[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic cyc(input logic v, input logic [9:0] d);
      rx_valid = v;
      rx_data  = d;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic add(input logic v, input logic [9:0] d, input logic tv,
                      input logic [7:0] td, input logic err);
      vec_t r;
      r.v = v; r.d = d; r.tv = tv; r.td = td; r.err = err;
      tab.push_back(r);
   endtask

   task automatic run_table(input string name);
      foreach (tab[i]) begin
         cyc(tab[i].v, tab[i].d);
         chk($sformatf("%s[%0d].tx_valid", name, i), 32'(tx_valid), 32'(tab[i].tv));
         chk($sformatf("%s[%0d].tx_data", name, i), 32'(tx_data), 32'(tab[i].td));
         chk($sformatf("%s[%0d].cmd_err", name, i), 32'(cmd_err), 32'(tab[i].err));
      end
      tab.delete();
   endtask

   task automatic chk_reset_outs(input string name);
      chk({name, ".tx_valid"}, 32'(tx_valid), 32'd0);
      chk({name, ".tx_data"}, 32'(tx_data), 32'd0);
      chk({name, ".cmd_err"}, 32'(cmd_err), 32'd0);
   endtask

   // Reference model: commands are judged by edge number; a read accepted at edge n
   // delivers at edge n+1 and blocks the port through edge n+2.
   logic [7:0] m_mem [256];
   logic [7:0] m_wa, m_ra, m_td, m_pend;
   logic       m_wok, m_rok;
   int         m_n, m_busy_until, m_tv_edge;

   task automatic model_reset();
      m_wa = 8'h00; m_ra = 8'h00; m_td = 8'h00; m_pend = 8'h00;
      m_wok = 1'b0; m_rok = 1'b0;
      m_n = 0; m_busy_until = -10; m_tv_edge = -10;
   endtask

   task automatic model_step(input logic v, input logic [9:0] d,
                             output logic etv, output logic [7:0] etd, output logic eerr);
      m_n++;
      eerr = 1'b0;
      etv  = (m_n == m_tv_edge);
      if (etv) m_td = m_pend;
      if (v) begin
         if (m_n <= m_busy_until) eerr = 1'b1;
         else begin
            case (d[9:8])
               2'd0: begin m_wa = d[7:0]; m_wok = 1'b1; end
               2'd1: if (m_wok) begin m_mem[m_wa] = d[7:0]; m_wa = m_wa + 8'd1; end
                     else eerr = 1'b1;
               2'd2: begin m_ra = d[7:0]; m_rok = 1'b1; end
               default: if (m_rok) begin
                     m_pend = m_mem[m_ra];
                     m_ra = m_ra + 8'd1;
                     m_tv_edge = m_n + 1;
                     m_busy_until = m_n + 2;
                  end else eerr = 1'b1;
            endcase
         end
      end
      etd = m_td;
   endtask

   task automatic model_cyc(input logic v, input logic [9:0] d, input string name);
      logic       etv, eerr;
      logic [7:0] etd;
      cyc(v, d);
      model_step(v, d, etv, etd, eerr);
      chk({name, ".tx_valid"}, 32'(tx_valid), 32'(etv));
      chk({name, ".tx_data"}, 32'(tx_data), 32'(etd));
      chk({name, ".cmd_err"}, 32'(cmd_err), 32'(eerr));
   endtask

   initial begin
      // Reset held for three cycles.
      rst = 1'b1;
      repeat (3) cyc(1'b0, 10'h000);
      chk_reset_outs("reset");
      rst = 1'b0;

      // Seed mem[0] before a reset so a dropped write to address 0 is visible later.
      add(1, 10'h000, 0, 8'h00, 0);
      add(1, 10'h13C, 0, 8'h00, 0);
      run_table("seed");

      rst = 1'b1;
      repeat (3) cyc(1'b0, 10'h000);
      chk_reset_outs("reset2");
      rst = 1'b0;

      // Missing address: both data commands dropped, mem[0] still 0x3C.
      add(1, 10'h155, 0, 8'h00, 1);
      add(1, 10'h300, 0, 8'h00, 1);
      add(0, 10'h000, 0, 8'h00, 0);
      add(1, 10'h200, 0, 8'h00, 0);
      add(1, 10'h300, 0, 8'h00, 0);
      add(0, 10'h000, 1, 8'h3C, 0);
      add(0, 10'h000, 0, 8'h3C, 0);
      // Single write then read.
      add(1, 10'h012, 0, 8'h3C, 0);
      add(1, 10'h1A5, 0, 8'h3C, 0);
      add(1, 10'h212, 0, 8'h3C, 0);
      add(1, 10'h300, 0, 8'h3C, 0);
      add(0, 10'h000, 1, 8'hA5, 0);
      add(0, 10'h000, 0, 8'hA5, 0);
      // Streaming across the 0xFF -> 0x00 wrap.
      add(1, 10'h0FF, 0, 8'hA5, 0);
      add(1, 10'h111, 0, 8'hA5, 0);
      add(1, 10'h122, 0, 8'hA5, 0);
      add(1, 10'h2FF, 0, 8'hA5, 0);
      add(1, 10'h300, 0, 8'hA5, 0);
      add(0, 10'h000, 1, 8'h11, 0);
      add(0, 10'h000, 0, 8'h11, 0);
      add(1, 10'h300, 0, 8'h11, 0);
      add(0, 10'h000, 1, 8'h22, 0);
      add(0, 10'h000, 0, 8'h22, 0);
      // WR_ADDR during RD_FETCH is dropped; wr_addr stays at 0x41.
      add(1, 10'h040, 0, 8'h22, 0);
      add(1, 10'h1C7, 0, 8'h22, 0);
      add(1, 10'h240, 0, 8'h22, 0);
      add(1, 10'h300, 0, 8'h22, 0);
      add(1, 10'h080, 1, 8'hC7, 1);
      add(0, 10'h000, 0, 8'hC7, 0);
      add(1, 10'h1D2, 0, 8'hC7, 0);
      add(1, 10'h300, 0, 8'hC7, 0);
      add(0, 10'h000, 1, 8'hD2, 0);
      add(0, 10'h000, 0, 8'hD2, 0);
      run_table("vec");

      // Reset asserted during RD_FETCH.
      cyc(1'b1, 10'h050);
      cyc(1'b1, 10'h19E);
      cyc(1'b1, 10'h250);
      cyc(1'b1, 10'h300);
      #1;
      rst = 1'b1;
      #1;
      chk_reset_outs("midrd_async");
      repeat (2) begin
         cyc(1'b0, 10'h000);
         chk("midrd_hold.tx_valid", 32'(tx_valid), 32'd0);
      end
      rst = 1'b0;
      cyc(1'b1, 10'h300);
      chk("midrd_flag.cmd_err", 32'(cmd_err), 32'd1);
      chk("midrd_flag.tx_valid", 32'(tx_valid), 32'd0);
      cyc(1'b0, 10'h000);
      chk("midrd_idle.tx_valid", 32'(tx_valid), 32'd0);
      chk("midrd_idle.cmd_err", 32'(cmd_err), 32'd0);
      cyc(1'b1, 10'h250);
      cyc(1'b1, 10'h300);
      cyc(1'b0, 10'h000);
      chk("midrd_reread.tx_valid", 32'(tx_valid), 32'd1);
      chk("midrd_reread.tx_data", 32'(tx_data), 32'h9E);
      cyc(1'b0, 10'h000);
      chk("midrd_reread_end.tx_valid", 32'(tx_valid), 32'd0);

      // Randomized traffic against the reference model, after filling the whole RAM.
      rst = 1'b1;
      repeat (2) cyc(1'b0, 10'h000);
      rst = 1'b0;
      model_reset();
      model_cyc(1'b1, 10'h000, "fill_addr");
      for (int i = 0; i < 256; i++)
         model_cyc(1'b1, {2'b01, 8'($urandom)}, "fill");
      for (int i = 0; i < 1500; i++) begin
         logic       v;
         logic [9:0] d;
         v = 1'($urandom_range(0, 1));
         d = 10'($urandom);
         model_cyc(v, d, $sformatf("rand[%0d]", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
